instr_fetch: RTL
================

// Module: instr_fetch
// PURPOSE
//  Instruction fetch unit: producer side of the CU instruction-load interface (irin/iri_in).
//  Owns the fetch PC and reads program bytes over a req/ack memory port.
//  Buffers prefetched bytes in a small FIFO and hands one byte to the CU per iri_in strobe.
//  A jump flushes the buffer and redirects fetching; in-flight data is discarded.
// PARAMETERS
//  ADDR_W  16  program address width; PC wraps modulo 2^ADDR_W
//  DEPTH   4   prefetch FIFO entries (power of 2, >=2)
// PORTS
//  clk        in   1       single clock, all state on rising edge
//  reset      in   1       synchronous, active-low (reset==0 at posedge clears state)
//  mem_req    out  1       memory read request, held until mem_ack
//  mem_addr   out  ADDR_W  read address, stable while mem_req=1
//  mem_ack    in   1       one-cycle ack; mem_data valid in same cycle
//  mem_data   in   8       returned byte
//  irin       out  8       FIFO head byte to CU (valid when ir_valid=1)
//  ir_valid   out  1       FIFO non-empty
//  iri_in     in   1       CU load strobe; pops head when ir_valid=1
//  ir_pc      out  ADDR_W  address of current head byte
//  jump       in   1       redirect request (one cycle)
//  jump_addr  in   ADDR_W  redirect target
//  fifo_count out  clog2(DEPTH)+1  occupied entries
// BEHAVIOUR
//  Reset: mem_req=0, mem_addr=0, fetch_pc=0, FIFO empty, ir_valid=0, irin=0,
//   ir_pc=0, fifo_count=0, state=IDLE. Reset mid-transfer abandons it; a late ack is ignored.
//  FSM: IDLE -> REQ when (fifo_count + outstanding) < DEPTH; mem_req=1, mem_addr=fetch_pc.
//   REQ + mem_ack: push mem_data with address fetch_pc, fetch_pc<=fetch_pc+1 (wraps), -> IDLE
//   (or stays REQ back-to-back if space remains; new addr next cycle).
//   REQ + jump (no ack): -> DRAIN; mem_req/mem_addr held unchanged (protocol: never withdraw req).
//   DRAIN + mem_ack: discard data, -> IDLE; fetch_pc already = jump target.
//  mem_req asserts the cycle after leaving reset; min fetch latency: ack on first req cycle
//   -> ir_valid=1 right after that edge.
//  Space rule: a request is issued only if fifo_count < DEPTH at issue; full FIFO -> no req.
//   Pop and push in same cycle allowed; count unchanged.
//  Pop: at posedge with ir_valid & iri_in & !jump: head advances, ir_pc to next entry's addr.
//   iri_in while empty: ignored, no underflow, irin holds 0.
//  Jump (highest priority): FIFO flushed, fifo_count=0, ir_valid=0 next cycle,
//   fetch_pc<=jump_addr, ir_pc<=jump_addr. Same-cycle pop is ignored. Same-cycle
//   mem_ack in REQ: data discarded, no DRAIN needed. Jump while in DRAIN: only
//   fetch_pc updated, stays DRAIN.
//  Each FIFO entry stores {addr, byte}; ir_pc = head addr, irin = head byte
//   (irin=0, ir_pc=fetch_pc when empty).
//  Wrap: fetch_pc 2^ADDR_W-1 -> 0 without stall.
// TESTING
//  1. reset=0 2 cycles, release; mem zero-wait returns 0xA5,0x3C -> mem_addr 0,1;
//     irin=0xA5 ir_pc=0 then, after iri_in, irin=0x3C ir_pc=1.
//  2. No iri_in, zero-wait mem -> exactly DEPTH(4) fetches, fifo_count=4, mem_req=0 thereafter;
//     one pop -> one new req at addr 4.
//  3. mem_ack delayed 3 cycles, jump to 0x0100 in 2nd wait cycle -> mem_addr held, acked
//     byte discarded, next req addr 0x0100, fifo_count=0 throughout.
//  4. jump to 0x0040 same cycle as iri_in and mem_ack -> no pop, ack data dropped,
//     ir_valid=0, next req addr 0x0040.
//  5. jump to 0xFFFF, fetch 3 bytes -> mem_addr 0xFFFF,0x0000,0x0001; ir_pc matches.
//  6. reset=0 while mem_req=1 -> mem_req=0 next cycle; ack on following cycle ignored,
//     fifo_count stays 0.

Source files
------------

// File: rtl/instr_fetch_if.sv
// Bundle between the instruction fetch unit, its program memory port and the CU.
// The master modport is the fetch unit; the slave modport is the memory/CU side.
interface instr_fetch_if #(
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 4
) ();
    localparam int COUNT_W = $clog2(DEPTH) + 1;

    logic               mem_req;
    logic [ADDR_W-1:0]  mem_addr;
    logic               mem_ack;
    logic [7:0]         mem_data;
    logic [7:0]         irin;
    logic               ir_valid;
    logic               iri_in;
    logic [ADDR_W-1:0]  ir_pc;
    logic               jump;
    logic [ADDR_W-1:0]  jump_addr;
    logic [COUNT_W-1:0] fifo_count;

    modport master (
        output mem_req, mem_addr, irin, ir_valid, ir_pc, fifo_count,
        input  mem_ack, mem_data, iri_in, jump, jump_addr
    );

    modport slave (
        input  mem_req, mem_addr, irin, ir_valid, ir_pc, fifo_count,
        output mem_ack, mem_data, iri_in, jump, jump_addr
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch unit: prefetches program bytes over a req/ack port into a
// small {addr, byte} FIFO and hands the head byte to the CU on each load strobe.
module instr_fetch #(
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic           clk,
    input  logic           reset,
    instr_fetch_if.master  bus
);
    localparam int COUNT_W = $clog2(DEPTH) + 1;
    localparam int PTR_W   = $clog2(DEPTH);
    localparam logic [COUNT_W-1:0] DEPTH_C = COUNT_W'(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

    state_t             state_q, state_d;
    logic               mem_req_q, mem_req_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               push, pop, not_empty;

    logic [ADDR_W-1:0]  fifo_addr_q [DEPTH];
    logic [7:0]         fifo_data_q [DEPTH];

    assign not_empty = (count_q != '0);
    // Jump outranks everything: a same-cycle ack or pop is simply dropped.
    assign push = (state_q == REQ) && bus.mem_ack && !bus.jump;
    assign pop  = not_empty && bus.iri_in && !bus.jump;

    always_comb begin
        state_d    = state_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        fetch_pc_d = fetch_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;

        if (bus.jump) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
                count_d  = count_d + COUNT_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
                count_d  = count_d - COUNT_W'(1);
            end
        end

        unique case (state_q)
            IDLE: begin
                if (bus.jump) begin
                    fetch_pc_d = bus.jump_addr;
                    state_d    = REQ;
                    mem_req_d  = 1'b1;
                    mem_addr_d = bus.jump_addr;
                end else if (count_q < DEPTH_C) begin
                    state_d    = REQ;
                    mem_req_d  = 1'b1;
                    mem_addr_d = fetch_pc_q;
                end
            end
            REQ: begin
                if (bus.jump) begin
                    fetch_pc_d = bus.jump_addr;
                    if (bus.mem_ack) begin
                        mem_addr_d = bus.jump_addr;
                    end else begin
                        // The bus may not withdraw a request; wait for its ack.
                        state_d = DRAIN;
                    end
                end else if (bus.mem_ack) begin
                    fetch_pc_d = fetch_pc_q + ADDR_W'(1);
                    if (count_d < DEPTH_C) begin
                        mem_addr_d = fetch_pc_q + ADDR_W'(1);
                    end else begin
                        state_d   = IDLE;
                        mem_req_d = 1'b0;
                    end
                end
            end
            DRAIN: begin
                if (bus.jump) begin
                    fetch_pc_d = bus.jump_addr;
                end
                if (bus.mem_ack) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            fetch_pc_q <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            fetch_pc_q <= fetch_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    // Storage needs no reset: the head is only exposed while the count is non-zero.
    always_ff @(posedge clk) begin
        if (reset && push) begin
            fifo_addr_q[wr_ptr_q] <= fetch_pc_q;
            fifo_data_q[wr_ptr_q] <= bus.mem_data;
        end
    end

    assign bus.mem_req    = mem_req_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.ir_valid   = not_empty;
    assign bus.fifo_count = count_q;
    assign bus.irin       = not_empty ? fifo_data_q[rd_ptr_q] : 8'h00;
    assign bus.ir_pc      = not_empty ? fifo_addr_q[rd_ptr_q] : fetch_pc_q;
endmodule
